alu_control_mc: RTL

ALU_CONTROL_MC -- requirements
Module: alu_control_mc

---
 rtl/alu_ctrl_pkg.sv | 47 ++++
 rtl/alu_ctrl_decode.sv | 54 +++++
 rtl/alu_control_mc.sv | 109 ++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control block: ALU op codes, funct codes,
// main-control op classes and the multi-cycle FSM states.
package alu_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_AND     = 4'd0,
        OP_OR      = 4'd1,
        OP_ADD     = 4'd2,
        OP_ILLEGAL = 4'd3,
        OP_DIV     = 4'd4,
        OP_MUL     = 4'd5,
        OP_SUB     = 4'd6,
        OP_SLT     = 4'd7,
        OP_SLL     = 4'd8,
        OP_SRL     = 4'd9,
        OP_XOR     = 4'd10,
        OP_NOR     = 4'd11
    } alu_op_e;

    typedef enum logic [1:0] {
        ALUOP_MEM   = 2'b00,
        ALUOP_BEQ   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_ADDI  = 2'b11
    } aluop_e;

    localparam logic [5:0] FUNCT_SLL = 6'h00;
    localparam logic [5:0] FUNCT_SRL = 6'h02;
    localparam logic [5:0] FUNCT_MUL = 6'h18;
    localparam logic [5:0] FUNCT_DIV = 6'h1A;
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_XOR = 6'h26;
    localparam logic [5:0] FUNCT_NOR = 6'h27;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUop/funct decode. Mul/div are only recognised when
// ALU_CTRL_MULDIV_EN is defined; otherwise they decode as illegal.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  logic [1:0] ALUop,
    input  logic [5:0] funct,
    output logic [3:0] op,
    output logic       illegal,
    output logic       is_mul,
    output logic       is_div
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        op      = OP_ILLEGAL;
        illegal = 1'b0;
        is_mul  = 1'b0;
        is_div  = 1'b0;
        case (ALUop)
            ALUOP_MEM, ALUOP_ADDI: op = OP_ADD;
            ALUOP_BEQ:             op = OP_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: op = OP_ADD;
                    FUNCT_SUB: op = OP_SUB;
                    FUNCT_AND: op = OP_AND;
                    FUNCT_OR:  op = OP_OR;
                    FUNCT_SLT: op = OP_SLT;
                    FUNCT_SLL: op = OP_SLL;
                    FUNCT_SRL: op = OP_SRL;
                    FUNCT_XOR: op = OP_XOR;
                    FUNCT_NOR: op = OP_NOR;
`ifdef ALU_CTRL_MULDIV_EN
                    FUNCT_MUL: begin
                        op     = OP_MUL;
                        is_mul = 1'b1;
                    end
                    FUNCT_DIV: begin
                        op     = OP_DIV;
                        is_div = 1'b1;
                    end
`endif
                    default: begin
                        op      = OP_ILLEGAL;
                        illegal = 1'b1;
                    end
                endcase
            end
            default: op = OP_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/alu_control_mc.sv
// Registered ALU control with a multi-cycle mul/div sequencer.
// Mul/div support is enabled by defining ALU_CTRL_MULDIV_EN.
module alu_control_mc
    import alu_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [1:0] ALUop,
    input  logic [5:0] funct,
    input  logic       flush,
    output logic [3:0] control_out,
    output logic       ctrl_valid,
    output logic       ex,
    output logic       stall,
    output logic       done,
    output logic       hilo_we
);

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    logic [3:0]       dec_op;
    logic             dec_illegal;
    logic             dec_is_mul;
    logic             dec_is_div;
    logic             accept;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    alu_ctrl_decode u_decode (
        .ALUop   (ALUop),
        .funct   (funct),
        .op      (dec_op),
        .illegal (dec_illegal),
        .is_mul  (dec_is_mul),
        .is_div  (dec_is_div)
    );

    assign accept = in_valid && !stall && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            control_out <= OP_ILLEGAL;
            ctrl_valid  <= 1'b0;
            ex          <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            ctrl_valid <= accept;
            ex         <= accept && dec_illegal;
            if (accept) begin
                control_out <= dec_op;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A mul/div accepted in the DONE cycle starts its own BUSY phase directly.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (accept && dec_is_mul) begin
                    state_d = ST_BUSY;
                    cnt_d   = MUL_CNT;
                end else if (accept && dec_is_div) begin
                    state_d = ST_BUSY;
                    cnt_d   = DIV_CNT;
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

`ifdef ALU_CTRL_MULDIV_EN
    assign stall = (state_q == ST_BUSY);
    assign done  = (state_q == ST_DONE);
`else
    assign stall = 1'b0;
    assign done  = 1'b0;
`endif
    assign hilo_we = done;

endmodule
